// File: rtl/hs_dsp_pkg.sv
// Shared DSP constants and types for the half-band decimation path.
package hs_dsp_pkg;

    localparam int DEFAULT_DW         = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef logic [DEFAULT_DW-1:0] sample_t;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is presented
// combinationally so a pop and a push of the same slot can share one edge.
module hs_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hs_decimator.sv
// Decimate-by-2 after a half-band FIR: keeps one polyphase and buffers it
// for a valid/ready consumer. Define HS_DECIMATOR_OVERFLOW_EN for a sticky drop flag.
module hs_decimator
    import hs_dsp_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [DW-1:0] i_data,
    input  logic          i_phase_sel,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_overflow
);

    logic          phase;
    logic          phase_sel_q;
    logic          keep;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;

    // Phase starts at 0 after reset so the first strobe is always the even sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase       <= 1'b0;
            phase_sel_q <= i_phase_sel;
        end else if (i_ce) begin
            phase <= ~phase;
        end
    end

    assign keep = !i_reset && i_ce && (phase == phase_sel_q);
    assign pop  = !i_reset && i_ready && !fifo_empty;
    assign push = keep && (!fifo_full || pop);

    hs_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .push    (push),
        .wr_data (i_data),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign o_valid = !fifo_empty;
    assign o_data  = o_valid ? fifo_head : '0;

`ifdef HS_DECIMATOR_OVERFLOW_EN
    logic overflow_q;

    // A kept sample that meets a full FIFO with no read in flight is lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else if (keep && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_overflow = overflow_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: doc/hs_decimator.md
HS_DECIMATOR -- requirements
Module: hs_decimator

Interface
REQ-001 Parameter DW, default 8, sample width in bits (two's complement).
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_ce  input  1  input sample strobe from the upstream half-band FIR; one sample per high cycle.
REQ-006 i_data  input  DW  half-band filtered sample; valid when i_ce=1.
REQ-007 i_phase_sel  input  1  selects the kept polyphase (0 = even samples, 1 = odd samples); sampled only while i_reset=1.
REQ-008 o_valid  output  1  FIFO head holds a decimated sample.
REQ-009 i_ready  input  1  downstream accepts o_data; a transfer occurs when o_valid=1 and i_ready=1.
REQ-010 o_data  output  DW  FIFO head sample.
REQ-011 o_overflow  output  1  sticky dropped-sample flag.

Function
REQ-012 A 1-bit phase register SHALL toggle on every i_ce=1 cycle and SHALL hold otherwise.
REQ-013 A sample SHALL be kept when i_ce=1 and the phase register equals the latched phase select; all other samples SHALL be discarded (decimate by 2).
REQ-014 A kept sample SHALL be written to the FIFO on that edge; with an empty FIFO, o_valid SHALL rise one cycle after the i_ce cycle, with o_data equal to the sample.
REQ-015 The FIFO SHALL preserve order; a read SHALL occur only on the transfer condition in REQ-009.
REQ-016 o_data SHALL be 0 whenever o_valid=0.
REQ-017 o_valid and o_data SHALL not change while o_valid=1 and i_ready=0 (stall), except by reset.
REQ-018 Full FIFO, kept sample, and no read in the same cycle: the sample SHALL be dropped, and the FIFO contents SHALL be left unchanged.
REQ-019 Full FIFO, kept sample, and a read in the same cycle: the write SHALL be accepted, and the occupancy SHALL stay at FIFO_DEPTH.
REQ-020 Empty FIFO: no read SHALL take effect, and i_ready SHALL be ignored.
REQ-021 Occupancy SHALL be tracked with pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full and empty SHALL be distinguished by the MSB.
REQ-022 Sample values SHALL pass through bit-exact; no arithmetic is applied.

Reset
REQ-023 While i_reset=1: phase register=0, FIFO empty, o_valid=0, o_data=0, o_overflow=0, and the latched phase select <= i_phase_sel.
REQ-024 Reset asserted mid-operation SHALL discard all buffered samples on that edge; i_ce SHALL be ignored during reset.
REQ-025 The first i_ce after reset release SHALL be treated as phase 0.

Configuration
REQ-026 Macro HS_DECIMATOR_OVERFLOW_EN defined: o_overflow SHALL set on the edge where a sample is dropped per REQ-018, and SHALL stay set until reset.
REQ-027 Macro HS_DECIMATOR_OVERFLOW_EN undefined: o_overflow SHALL be constant 0, drops per REQ-018 SHALL be silent, and no flag logic SHALL be synthesized; the port SHALL exist in both builds.

Structure
REQ-028 Shared package hs_dsp_pkg SHALL hold the default sample width constant (8), the sample typedef, and the default FIFO depth constant (4).
REQ-029 The FIFO SHALL be a sub-module hs_sync_fifo (parameters DW and DEPTH; push, pop, full, empty, head data); the phase logic and handshake SHALL stay in hs_decimator.

Verification
REQ-030 Reset test: drive i_reset=1 for 2 cycles with i_ce=1 and i_data=8'h7F -> o_valid=0, o_data=8'h00, o_overflow=0 throughout.
REQ-031 Decimation test: i_phase_sel=0, i_ready=1, i_ce=1 continuously, i_data=1,2,3,4,5,6 -> o_data sequence 1,3,5, each valid one cycle after its input.
REQ-032 Odd-phase test: i_phase_sel=1 during reset, same stimulus as REQ-031 -> o_data sequence 2,4,6.
REQ-033 Backpressure/overflow test: i_ready=0, 12 inputs 8'h10..8'h1B with phase 0 -> 4 buffered (10,12,14,16), o_overflow=1 with the macro defined (0 without); then i_ready=1 -> drains 10,12,14,16, then o_valid=0.
REQ-034 Full simultaneous test: FIFO full, i_ready=1 on the same cycle a kept sample 8'hA5 arrives -> no drop, o_overflow unchanged, 8'hA5 emerges 4th.
REQ-035 Mid-run reset test: FIFO holding 3 samples, pulse i_reset for 1 cycle -> o_valid=0 next cycle; next input pair 8'h3C,8'h3D -> 8'h3C output only.
